dmem_arbiter: RTL and testbench

- Shares the single multi-cycle data memory between two requesters.
  - Port 0: pipeline MEM stage.
  - Port 1: debug/loader port.
- Captures one request at a time, holds address/data/WE stable until the memory asserts Ready, then returns read data with a one-cycle Done pulse.
- Per-port Stall outputs freeze the owning requester.
- A timeout guard prevents a hung memory from deadlocking the pipeline.

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_arb_pick.sv | 37 +++
 rtl/dmem_arbiter.sv | 152 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants for the data-memory arbiter (FSM encoding,
// abort read pattern, requester port indices).
package dmem_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  // Returned to the owner instead of memory data when an access is aborted.
  localparam logic [31:0] ABORT_WORD = 32'hDEADBEEF;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational winner select between the two requesters.
// DMEM_ARB_RR_EN selects round-robin on contention; default is fixed P0 priority.
module dmem_arb_pick
  import dmem_pkg::*;
(
  input  logic p0_req,
  input  logic p1_req,
  input  logic last_owner,
  output logic grant_valid,
  output logic winner
);

`ifdef DMEM_ARB_RR_EN
  always_comb begin
    grant_valid = p0_req | p1_req;
    winner      = PORT0;
    if (p0_req && p1_req) begin
      winner = ~last_owner;
    end else if (p1_req) begin
      winner = PORT1;
    end
  end
`else
  // Port 1 may starve here; it is only used while the pipeline is halted.
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  always_comb begin
    grant_valid = p0_req | p1_req;
    winner      = PORT0;
    if (!p0_req && p1_req) begin
      winner = PORT1;
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one multi-cycle data memory between the MEM stage (port 0)
// and the debug/loader port (port 1). Define DMEM_ARB_RR_EN for round-robin contention.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW      = 32,
  parameter int TIMEOUT = 16,
  parameter int CW      = 5
) (
  input  logic          CLK,
  input  logic          ResetN,
  input  logic          P0Req,
  input  logic          P0WE,
  input  logic [AW-1:0] P0Addr,
  input  logic [AW-1:0] P0WD,
  output logic          P0Done,
  output logic [AW-1:0] P0RD,
  output logic          P0Stall,
  input  logic          P1Req,
  input  logic          P1WE,
  input  logic [AW-1:0] P1Addr,
  input  logic [AW-1:0] P1WD,
  output logic          P1Done,
  output logic [AW-1:0] P1RD,
  output logic          P1Stall,
  output logic          MemValid,
  output logic          MemWE,
  output logic [AW-1:0] MemA,
  output logic [AW-1:0] MemWD,
  input  logic          MemReady,
  input  logic [AW-1:0] MemRD,
  output logic          Owner,
  output logic          TimeoutErr,
  output logic [1:0]    dbg_state
);

  // Handshakes: a requester holds PxReq (level) until it sees the one-cycle
  // PxDone; toward memory, MemValid with stable MemA/MemWD/MemWE is held until
  // the cycle MemReady is high, which completes the access in that cycle.

`ifdef DMEM_ARB_RR_EN
  localparam logic OWNER_RST = PORT1;
`else
  localparam logic OWNER_RST = PORT0;
`endif

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          grant_valid;
  logic          winner;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [AW-1:0] sel_wd;
  logic          timeout_hit;
  logic          finish_access;
  logic [AW-1:0] resp_data;

  dmem_arb_pick u_pick (
    .p0_req      (P0Req),
    .p1_req      (P1Req),
    .last_owner  (Owner),
    .grant_valid (grant_valid),
    .winner      (winner)
  );

  always_comb begin
    sel_we   = P0WE;
    sel_addr = P0Addr;
    sel_wd   = P0WD;
    if (winner == PORT1) begin
      sel_we   = P1WE;
      sel_addr = P1Addr;
      sel_wd   = P1WD;
    end
  end

  assign timeout_hit   = (cnt == CW'(TIMEOUT - 1));
  // MemReady wins over the timeout when both land in the same cycle.
  assign finish_access = (state == ST_BUSY) && (MemReady || timeout_hit);

  always_comb begin
    resp_data = MemWE ? '0 : MemRD;
    if (!MemReady) begin
      resp_data = AW'(ABORT_WORD);
    end
  end

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      state    <= ST_IDLE;
      MemValid <= 1'b0;
      MemWE    <= 1'b0;
      MemA     <= '0;
      MemWD    <= '0;
      Owner    <= OWNER_RST;
      cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            state    <= ST_BUSY;
            MemValid <= 1'b1;
            MemWE    <= sel_we;
            MemA     <= {sel_addr[AW-1:2], 2'b00};
            MemWD    <= sel_wd;
            Owner    <= winner;
            cnt      <= '0;
          end
        end
        ST_BUSY: begin
          if (cnt != {CW{1'b1}}) begin
            cnt <= cnt + 1'b1;
          end
          if (finish_access) begin
            MemValid <= 1'b0;
            MemWE    <= 1'b0;
            state    <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      P0Done     <= 1'b0;
      P1Done     <= 1'b0;
      P0RD       <= '0;
      P1RD       <= '0;
      TimeoutErr <= 1'b0;
    end else begin
      P0Done <= finish_access && (Owner == PORT0);
      P1Done <= finish_access && (Owner == PORT1);
      if (finish_access && (Owner == PORT0)) begin
        P0RD <= resp_data;
      end
      if (finish_access && (Owner == PORT1)) begin
        P1RD <= resp_data;
      end
      if (finish_access && !MemReady) begin
        TimeoutErr <= 1'b1;
      end
    end
  end

  assign P0Stall   = P0Req & ~P0Done;
  assign P1Stall   = P1Req & ~P1Done;
  assign dbg_state = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a small word memory
// model whose Ready latency is set per test (0 = never ready).
module tb_dmem_arbiter;

  logic        CLK = 1'b0;
  logic        ResetN = 1'b0;
  logic        P0Req = 1'b0, P0WE = 1'b0;
  logic [31:0] P0Addr = '0, P0WD = '0;
  logic        P1Req = 1'b0, P1WE = 1'b0;
  logic [31:0] P1Addr = '0, P1WD = '0;
  logic        P0Done, P0Stall, P1Done, P1Stall;
  logic [31:0] P0RD, P1RD;
  logic        MemValid, MemWE, MemReady;
  logic [31:0] MemA, MemWD, MemRD;
  logic        Owner, TimeoutErr;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

`ifdef DMEM_ARB_RR_EN
  localparam logic OWNER_RST = 1'b1;
`else
  localparam logic OWNER_RST = 1'b0;
`endif

  dmem_arbiter #(.AW(32), .TIMEOUT(16), .CW(5)) dut (
    .CLK(CLK), .ResetN(ResetN),
    .P0Req(P0Req), .P0WE(P0WE), .P0Addr(P0Addr), .P0WD(P0WD),
    .P0Done(P0Done), .P0RD(P0RD), .P0Stall(P0Stall),
    .P1Req(P1Req), .P1WE(P1WE), .P1Addr(P1Addr), .P1WD(P1WD),
    .P1Done(P1Done), .P1RD(P1RD), .P1Stall(P1Stall),
    .MemValid(MemValid), .MemWE(MemWE), .MemA(MemA), .MemWD(MemWD),
    .MemReady(MemReady), .MemRD(MemRD),
    .Owner(Owner), .TimeoutErr(TimeoutErr), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // memory model: word i initialised to 0x1000_0000 + i
  logic [31:0] mem [0:63];
  int lat = 3;
  int busy_cnt = 0;
  assign MemReady = MemValid && (lat != 0) && (busy_cnt == lat - 1);
  assign MemRD    = mem[MemA[7:2]];

  always @(posedge CLK) begin
    if (!ResetN) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + i;
      busy_cnt <= 0;
    end else begin
      if (MemValid && !MemReady) busy_cnt <= busy_cnt + 1;
      else busy_cnt <= 0;
      if (MemValid && MemReady && MemWE) mem[MemA[7:2]] <= MemWD;
    end
  end

  // driver tasks
  task automatic apply_reset();
    @(negedge CLK);
    ResetN = 1'b0;
    P0Req = 1'b0; P1Req = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    ResetN = 1'b1;
  endtask

  task automatic drive_p0(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    P0Req = 1'b1; P0WE = we; P0Addr = addr; P0WD = wd;
  endtask

  task automatic drive_p1(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    P1Req = 1'b1; P1WE = we; P1Addr = addr; P1WD = wd;
  endtask

  // Observes one access up to the owner's Done; returns at the Done negedge.
  task automatic run_until_done(input logic port, output int busy_cycles, output logic held,
                                output logic got_done, output logic [31:0] rd,
                                output logic [31:0] a_seen, output logic we_seen,
                                output logic [31:0] wd_seen);
    logic first;
    busy_cycles = 0; held = 1'b1; got_done = 1'b0; rd = '0;
    a_seen = '0; we_seen = 1'b0; wd_seen = '0; first = 1'b1;
    for (int i = 0; i < 100 && !got_done; i++) begin
      @(negedge CLK);
      if (MemValid) begin
        if (first) begin
          a_seen = MemA; we_seen = MemWE; wd_seen = MemWD; first = 1'b0;
        end else if (MemA !== a_seen || MemWE !== we_seen || MemWD !== wd_seen) begin
          held = 1'b0;
        end
        busy_cycles++;
      end
      if ((port == 1'b0 && P0Done === 1'b1) || (port == 1'b1 && P1Done === 1'b1)) begin
        got_done = 1'b1;
        rd = port ? P1RD : P0RD;
      end
    end
  endtask

  // tests
  task automatic test_reset();
    apply_reset();
    total++;
    if ({MemValid, MemWE, MemA, MemWD, P0Done, P1Done, P0RD, P1RD, Owner, TimeoutErr, dbg_state}
        !== {1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, OWNER_RST, 1'b0, 2'b00}) begin
      bad++;
      $display("FAIL reset_values: valid=%0b we=%0b a=%h wd=%h d0=%0b d1=%0b rd0=%h rd1=%h own=%0b terr=%0b st=%0d, want all zero with owner=%0b",
               MemValid, MemWE, MemA, MemWD, P0Done, P1Done, P0RD, P1RD, Owner, TimeoutErr, dbg_state, OWNER_RST);
    end
  endtask

  task automatic test_read();
    int n; logic held, got; logic [31:0] rd, a, wd; logic we;
    lat = 3;
    @(negedge CLK);
    drive_p0(1'b0, 32'h0000_0010, 32'h0);
    #1;
    total++;
    if (P0Stall !== 1'b1) begin bad++; $display("FAIL read_stall_high: got %0b want 1", P0Stall); end
    run_until_done(1'b0, n, held, got, rd, a, we, wd);
    total++;
    if (!got || n != 3 || !held || a !== 32'h10 || we !== 1'b0) begin
      bad++;
      $display("FAIL read_busy: done=%0b cycles=%0d held=%0b a=%h we=%0b want 1/3/1/00000010/0", got, n, held, a, we);
    end
    total++;
    if (rd !== 32'h1000_0004) begin bad++; $display("FAIL read_data: got %h want 10000004", rd); end
    total++;
    if (P0Stall !== 1'b0 || MemValid !== 1'b0) begin
      bad++; $display("FAIL read_stall_low: stall=%0b valid=%0b want 0/0", P0Stall, MemValid);
    end
    P0Req = 1'b0;
    @(negedge CLK);
    total++;
    if (P0Done !== 1'b0 || P0RD !== 32'h1000_0004) begin
      bad++; $display("FAIL read_pulse_hold: done=%0b rd=%h want 0/10000004", P0Done, P0RD);
    end
  endtask

  task automatic test_write();
    int n; logic held, got; logic [31:0] rd, a, wd; logic we;
    lat = 3;
    @(negedge CLK);
    drive_p0(1'b1, 32'h0000_0007, 32'hCAFE_F00D);
    run_until_done(1'b0, n, held, got, rd, a, we, wd);
    P0Req = 1'b0;
    total++;
    if (!got || n != 3 || !held || a !== 32'h4 || we !== 1'b1 || wd !== 32'hCAFE_F00D) begin
      bad++;
      $display("FAIL write_busy: done=%0b cycles=%0d held=%0b a=%h we=%0b wd=%h want 1/3/1/00000004/1/cafef00d",
               got, n, held, a, we, wd);
    end
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL write_rd_zero: got %h want 0", rd); end
    @(negedge CLK);
    drive_p0(1'b0, 32'h0000_0004, 32'h0);
    run_until_done(1'b0, n, held, got, rd, a, we, wd);
    P0Req = 1'b0;
    total++;
    if (!got || rd !== 32'hCAFE_F00D) begin
      bad++; $display("FAIL write_readback: done=%0b rd=%h want 1/cafef00d", got, rd);
    end
  endtask

  task automatic test_ready_at_limit();
    int n; logic held, got; logic [31:0] rd, a, wd; logic we;
    lat = 16;
    @(negedge CLK);
    drive_p0(1'b0, 32'h0000_0020, 32'h0);
    run_until_done(1'b0, n, held, got, rd, a, we, wd);
    P0Req = 1'b0;
    total++;
    if (!got || n != 16 || rd !== 32'h1000_0008 || TimeoutErr !== 1'b0) begin
      bad++;
      $display("FAIL ready_at_limit: done=%0b cycles=%0d rd=%h terr=%0b want 1/16/10000008/0", got, n, rd, TimeoutErr);
    end
    lat = 3;
  endtask

  task automatic test_contention();
    int n; logic held, got; logic [31:0] rd, a, wd; logic we;
    apply_reset();
    lat = 3;
    drive_p0(1'b0, 32'h0000_0008, 32'h0);
    drive_p1(1'b0, 32'h0000_000C, 32'h0);
    run_until_done(1'b0, n, held, got, rd, a, we, wd);
    total++;
    if (!got || rd !== 32'h1000_0002 || Owner !== 1'b0 || P1Stall !== 1'b1) begin
      bad++;
      $display("FAIL contention_p0_first: done=%0b rd=%h own=%0b p1stall=%0b want 1/10000002/0/1", got, rd, Owner, P1Stall);
    end
    P0Req = 1'b0;
    @(negedge CLK);
    total++;
    if (MemValid !== 1'b0) begin bad++; $display("FAIL contention_gap: valid=%0b want 0", MemValid); end
    @(negedge CLK);
    total++;
    if (MemValid !== 1'b1 || Owner !== 1'b1 || MemA !== 32'hC) begin
      bad++; $display("FAIL contention_p1_grant: valid=%0b own=%0b a=%h want 1/1/0000000c", MemValid, Owner, MemA);
    end
    run_until_done(1'b1, n, held, got, rd, a, we, wd);
    P1Req = 1'b0;
    total++;
    if (!got || rd !== 32'h1000_0003) begin
      bad++; $display("FAIL contention_p1_data: done=%0b rd=%h want 1/10000003", got, rd);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_port [4];
    logic seen_port;
    logic got;
`ifdef DMEM_ARB_RR_EN
    exp_port = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_port = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    apply_reset();
    lat = 3;
    drive_p0(1'b0, 32'h0000_0040, 32'h0);
    drive_p1(1'b0, 32'h0000_0044, 32'h0);
    for (int k = 0; k < 4; k++) begin
      got = 1'b0; seen_port = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
        @(negedge CLK);
        if (P0Done === 1'b1 || P1Done === 1'b1) begin
          got = 1'b1; seen_port = P1Done;
        end
      end
      total++;
      if (!got || seen_port !== exp_port[k]) begin
        bad++; $display("FAIL back_to_back_%0d: done=%0b port=%0b want 1/%0b", k, got, seen_port, exp_port[k]);
      end
    end
    P0Req = 1'b0; P1Req = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_timeout();
    int n; logic held, got; logic [31:0] rd, a, wd; logic we;
    lat = 0;
    @(negedge CLK);
    drive_p1(1'b0, 32'h0000_0030, 32'h0);
    run_until_done(1'b1, n, held, got, rd, a, we, wd);
    P1Req = 1'b0;
    total++;
    if (!got || n != 16 || rd !== 32'hDEAD_BEEF || TimeoutErr !== 1'b1) begin
      bad++;
      $display("FAIL timeout_abort: done=%0b cycles=%0d rd=%h terr=%0b want 1/16/deadbeef/1", got, n, rd, TimeoutErr);
    end
    lat = 3;
    @(negedge CLK);
    drive_p0(1'b0, 32'h0000_0010, 32'h0);
    run_until_done(1'b0, n, held, got, rd, a, we, wd);
    P0Req = 1'b0;
    total++;
    if (!got || rd !== 32'h1000_0004 || TimeoutErr !== 1'b1 || P1RD !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL timeout_recover: done=%0b rd=%h terr=%0b p1rd=%h want 1/10000004/1/deadbeef", got, rd, TimeoutErr, P1RD);
    end
  endtask

  task automatic test_mid_reset();
    int n; logic held, got; logic [31:0] rd, a, wd; logic we;
    lat = 3;
    @(negedge CLK);
    drive_p0(1'b0, 32'h0000_0014, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    total++;
    if (MemValid !== 1'b1 || dbg_state !== 2'b01) begin
      bad++; $display("FAIL midreset_busy: valid=%0b st=%0d want 1/1", MemValid, dbg_state);
    end
    ResetN = 1'b0;
    #1;
    total++;
    if ({MemValid, MemWE, MemA, P0Done, P1Done, P0RD, P1RD, Owner, TimeoutErr, dbg_state}
        !== {1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, OWNER_RST, 1'b0, 2'b00}) begin
      bad++;
      $display("FAIL midreset_values: valid=%0b we=%0b a=%h d0=%0b rd0=%h rd1=%h own=%0b terr=%0b st=%0d",
               MemValid, MemWE, MemA, P0Done, P0RD, P1RD, Owner, TimeoutErr, dbg_state);
    end
    @(negedge CLK);
    total++;
    if (P0Done !== 1'b0) begin bad++; $display("FAIL midreset_no_done: got %0b want 0", P0Done); end
    ResetN = 1'b1;
    @(negedge CLK);
    total++;
    if (MemValid !== 1'b1 || Owner !== 1'b0 || MemA !== 32'h14) begin
      bad++; $display("FAIL midreset_regrant: valid=%0b own=%0b a=%h want 1/0/00000014", MemValid, Owner, MemA);
    end
    run_until_done(1'b0, n, held, got, rd, a, we, wd);
    P0Req = 1'b0;
    total++;
    if (!got || rd !== 32'h1000_0005) begin
      bad++; $display("FAIL midreset_complete: done=%0b rd=%h want 1/10000005", got, rd);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_ready_at_limit();
    test_contention();
    test_back_to_back();
    test_timeout();
    test_mid_reset();
    repeat (2) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
